// File: rtl/apb_irq_sequencer.sv
// rtl/apb_irq_sequencer.sv - APB-configured 32-line interrupt sequencer with req/ack/EOI handshake
module apb_irq_sequencer #(
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [31:0]               signal_i,
    output logic                      irq_req_o,
    output logic [4:0]                irq_id_o,
    input  logic                      irq_ack_i,
    output logic                      irq_busy_o
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mask_q, mask_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] sig_q, sig_d;
    logic [4:0]  rr_ptr_q, rr_ptr_d;
    logic        mode_q, mode_d;
    logic        irq_req_q, irq_req_d;
    logic [4:0]  irq_id_q, irq_id_d;
    logic        irq_busy_q, irq_busy_d;

    logic        apb_wr, apb_rd, eoi_wr;
    logic [2:0]  reg_sel;
    logic [31:0] set_vec, clr_vec, edge_vec, ack_clear, pend_noack, eligible;
    logic [4:0]  base, idx, winner;
    logic        found;
    logic        unused_paddr;

    assign apb_wr       = PSEL && PENABLE && PWRITE;
    assign apb_rd       = PSEL && PENABLE && !PWRITE;
    assign reg_sel      = PADDR[4:2];
    assign eoi_wr       = apb_wr && (reg_sel == 3'd4);
    assign PREADY       = 1'b1;
    assign PSLVERR      = 1'b0;
    assign unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

    assign irq_req_o  = irq_req_q;
    assign irq_id_o   = irq_id_q;
    assign irq_busy_o = irq_busy_q;

    always_comb begin
        PRDATA = '0;
        if (apb_rd) begin
            case (reg_sel)
                3'd0:    PRDATA = mask_q;
                3'd1:    PRDATA = pending_q;
                3'd3:    PRDATA = {22'b0, state_q, irq_busy_q, irq_req_q, 1'b0, irq_id_q};
                3'd5:    PRDATA = {31'b0, mode_q};
                default: PRDATA = '0;
            endcase
        end
    end

    // Fixed mode is a round-robin search anchored at line 0.
    always_comb begin
        eligible = pending_q & mask_q;
        base     = mode_q ? rr_ptr_q : 5'd0;
        found    = 1'b0;
        winner   = '0;
        idx      = '0;
        for (int i = 0; i < 32; i++) begin
            idx = base + 5'(i);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        sig_d      = signal_i;
        edge_vec   = signal_i & ~sig_q;
        mask_d     = (apb_wr && reg_sel == 3'd0) ? PWDATA : mask_q;
        mode_d     = (apb_wr && reg_sel == 3'd5) ? PWDATA[0] : mode_q;
        set_vec    = (apb_wr && reg_sel == 3'd1) ? PWDATA : '0;
        clr_vec    = (apb_wr && reg_sel == 3'd2) ? PWDATA : '0;
        pend_noack = (pending_q & ~clr_vec) | set_vec | edge_vec;

        state_d    = state_q;
        irq_req_d  = irq_req_q;
        irq_id_d   = irq_id_q;
        irq_busy_d = irq_busy_q;
        rr_ptr_d   = rr_ptr_q;
        ack_clear  = '0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    irq_id_d  = winner;
                    irq_req_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                // Ack takes priority over a same-cycle clear or unmask of the requested line.
                if (irq_ack_i) begin
                    ack_clear  = 32'd1 << irq_id_q;
                    irq_req_d  = 1'b0;
                    irq_busy_d = 1'b1;
                    rr_ptr_d   = irq_id_q + 5'd1;
                    state_d    = ST_SERVICE;
                end else if (!pend_noack[irq_id_q] || !mask_d[irq_id_q]) begin
                    irq_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (eoi_wr) begin
                    irq_busy_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pending_d = (pending_q & ~clr_vec & ~ack_clear) | set_vec | edge_vec;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            pending_q  <= '0;
            sig_q      <= '0;
            rr_ptr_q   <= '0;
            mode_q     <= 1'b0;
            irq_req_q  <= 1'b0;
            irq_id_q   <= '0;
            irq_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            pending_q  <= pending_d;
            sig_q      <= sig_d;
            rr_ptr_q   <= rr_ptr_d;
            mode_q     <= mode_d;
            irq_req_q  <= irq_req_d;
            irq_id_q   <= irq_id_d;
            irq_busy_q <= irq_busy_d;
        end
    end
endmodule

// File: tb/tb_apb_irq_sequencer.sv
// tb/tb_apb_irq_sequencer.sv - directed and randomized checks of apb_irq_sequencer against a reference model
module tb_apb_irq_sequencer;
    logic        HCLK;
    logic        HRESETn;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic        pwr, psel, pen;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] sig;
    logic        irq_req, irq_ack, irq_busy;
    logic [4:0]  irq_id;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_prdata;
    logic [31:0] rd;

    // Reference model state: states 0=IDLE, 1=REQ, 2=SERVICE
    logic [31:0] m_mask, m_pend, m_sig;
    int          m_rr, m_id, m_st;
    bit          m_mode, m_req, m_busy;

    apb_irq_sequencer #(.APB_ADDR_WIDTH(12)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(paddr), .PWDATA(pwdata),
        .PWRITE(pwr), .PSEL(psel), .PENABLE(pen), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .signal_i(sig),
        .irq_req_o(irq_req), .irq_id_o(irq_id), .irq_ack_i(irq_ack),
        .irq_busy_o(irq_busy)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [31:0] el, input int from);
        for (int i = 0; i < 32; i++)
            if (el[(from + i) % 32]) return (from + i) % 32;
        return -1;
    endfunction

    function automatic logic [31:0] model_prdata();
        logic [4:0] idv;
        logic [1:0] stv;
        idv = 5'(m_id);
        stv = 2'(m_st);
        if (!(psel && pen && !pwr)) return 32'd0;
        case (paddr[4:2])
            3'd0:    return m_mask;
            3'd1:    return m_pend;
            3'd3:    return {22'b0, stv, m_busy, m_req, 1'b0, idv};
            3'd5:    return {31'b0, m_mode};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_mask = 0; m_pend = 0; m_sig = 0; m_rr = 0; m_id = 0; m_st = 0;
        m_mode = 0; m_req = 0; m_busy = 0;
    endtask

    task automatic model_step();
        bit          wr;
        int          r, w;
        logic [31:0] setv, clrv, nmask, npend;
        wr    = psel && pen && pwr;
        r     = int'(paddr[4:2]);
        setv  = (wr && r == 1) ? pwdata : 32'd0;
        clrv  = (wr && r == 2) ? pwdata : 32'd0;
        nmask = (wr && r == 0) ? pwdata : m_mask;
        npend = (m_pend & ~clrv) | setv | (sig & ~m_sig);
        if (m_st == 0) begin
            w = pick(m_pend & m_mask, m_mode ? m_rr : 0);
            if (w >= 0) begin m_id = w; m_req = 1; m_st = 1; end
        end else if (m_st == 1) begin
            if (irq_ack) begin
                npend = (m_pend & ~clrv & ~(32'd1 << m_id)) | setv | (sig & ~m_sig);
                m_req = 0; m_busy = 1; m_rr = (m_id + 1) % 32; m_st = 2;
            end else if (!npend[m_id] || !nmask[m_id]) begin
                m_req = 0; m_st = 0;
            end
        end else if (wr && r == 4) begin
            m_busy = 0; m_st = 0;
        end
        if (wr && r == 5) m_mode = pwdata[0];
        m_mask = nmask;
        m_pend = npend;
        m_sig  = sig;
    endtask

    task automatic cyc();
        #1;
        last_prdata = PRDATA;
        check("prdata", PRDATA, model_prdata());
        @(posedge HCLK);
        model_step();
        #1;
        check("irq_req", {31'b0, irq_req}, {31'b0, m_req});
        check("irq_id", {27'b0, irq_id}, 32'(m_id[4:0]));
        check("irq_busy", {31'b0, irq_busy}, {31'b0, m_busy});
    endtask

    task automatic apb_write(input int reg_idx, input logic [31:0] data);
        psel = 1; pen = 0; pwr = 1; paddr = 12'(reg_idx << 2); pwdata = data;
        cyc();
        pen = 1;
        cyc();
        psel = 0; pen = 0; pwr = 0;
    endtask

    task automatic apb_read(input int reg_idx, output logic [31:0] data);
        psel = 1; pen = 0; pwr = 0; paddr = 12'(reg_idx << 2);
        cyc();
        pen = 1;
        cyc();
        data = last_prdata;
        psel = 0; pen = 0;
    endtask

    task automatic ack_cycle();
        irq_ack = 1;
        cyc();
        irq_ack = 0;
    endtask

    initial begin
        HRESETn = 1; psel = 0; pen = 0; pwr = 0; paddr = 0; pwdata = 0;
        sig = 0; irq_ack = 0;
        model_reset();
        #2 HRESETn = 0;
        #1;
        check("rst_req", {31'b0, irq_req}, 32'd0);
        check("rst_busy", {31'b0, irq_busy}, 32'd0);
        check("rst_id", {27'b0, irq_id}, 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1;
        apb_read(0, rd); check("rst_mask", rd, 32'd0);
        apb_read(1, rd); check("rst_pending", rd, 32'd0);
        check("pready", {31'b0, PREADY}, 32'd1);
        check("pslverr", {31'b0, PSLVERR}, 32'd0);

        // Basic pulse on line 0
        apb_write(0, 32'h1);
        sig = 32'h1;
        cyc();
        check("lat_n_req", {31'b0, irq_req}, 32'd0);
        cyc();
        check("lat_n1_req", {31'b0, irq_req}, 32'd1);
        check("lat_n1_id", {27'b0, irq_id}, 32'd0);
        apb_read(1, rd); check("pend_line0", rd, 32'h1);
        sig = 0;
        ack_cycle();
        check("ack_busy", {31'b0, irq_busy}, 32'd1);
        check("ack_req", {31'b0, irq_req}, 32'd0);
        apb_read(1, rd); check("ack_pend_cleared", rd, 32'h0);
        apb_write(4, 32'h0);
        check("eoi_busy", {31'b0, irq_busy}, 32'd0);
        apb_read(3, rd); check("eoi_status_idle", rd, 32'h0);

        // Fixed priority
        apb_write(0, 32'hFFFF_FFFF);
        apb_write(1, 32'h0000_8010);
        cyc();
        check("fix_first", {27'b0, irq_id}, 32'd4);
        ack_cycle();
        apb_write(4, 0);
        cyc();
        check("fix_second", {27'b0, irq_id}, 32'd15);
        check("fix_second_req", {31'b0, irq_req}, 32'd1);
        ack_cycle();
        apb_write(4, 0);
        // Round-robin from rr_ptr=5 after serving line 4
        apb_write(1, 32'h10);
        cyc(); ack_cycle(); apb_write(4, 0);
        apb_write(5, 32'h1);
        apb_read(5, rd); check("mode_rb", rd, 32'h1);
        apb_write(1, 32'h0000_8010);
        cyc();
        check("rr_first", {27'b0, irq_id}, 32'd15);
        ack_cycle(); apb_write(4, 0); cyc();
        check("rr_wrap", {27'b0, irq_id}, 32'd4);
        ack_cycle(); apb_write(4, 0);
        // Service 31 so rr_ptr wraps to 0
        apb_write(1, 32'h8000_0000);
        cyc(); check("rr_31", {27'b0, irq_id}, 32'd31);
        ack_cycle(); apb_write(4, 0);
        apb_write(1, 32'h8000_0001);
        cyc(); check("rr_ptr0", {27'b0, irq_id}, 32'd0);
        ack_cycle(); apb_write(4, 0); cyc();
        check("rr_then31", {27'b0, irq_id}, 32'd31);
        ack_cycle(); apb_write(4, 0);

        // Retract and ack-wins
        apb_write(5, 32'h0);
        apb_write(1, 32'h80);
        cyc(); check("ret_req", {31'b0, irq_req}, 32'd1);
        apb_write(2, 32'h80);
        check("ret_dropped", {31'b0, irq_req}, 32'd0);
        apb_read(3, rd); check("ret_status", rd, 32'h0000_0007);
        apb_write(1, 32'h80);
        cyc();
        psel = 1; pen = 0; pwr = 1; paddr = 12'(2 << 2); pwdata = 32'h80;
        cyc();
        pen = 1; irq_ack = 1;
        cyc();
        psel = 0; pen = 0; pwr = 0; irq_ack = 0;
        check("ackwin_busy", {31'b0, irq_busy}, 32'd1);
        check("ackwin_id", {27'b0, irq_id}, 32'd7);
        apb_write(4, 0);

        // Collisions
        apb_write(0, 32'h0);
        psel = 1; pen = 0; pwr = 1; paddr = 12'(2 << 2); pwdata = 32'h8;
        cyc();
        pen = 1; sig = 32'h8;
        cyc();
        psel = 0; pen = 0; pwr = 0;
        apb_read(1, rd); check("set_beats_clear", rd, 32'h8);
        check("masked_no_req", {31'b0, irq_req}, 32'd0);
        apb_write(0, 32'h8);
        cyc(); check("unmask_req", {31'b0, irq_req}, 32'd1);
        ack_cycle();
        sig = 0; cyc();
        sig = 32'h8; cyc();
        apb_read(1, rd); check("inservice_edge", rd, 32'h8);
        apb_write(4, 0);
        cyc();
        check("reserve_req", {31'b0, irq_req}, 32'd1);
        check("reserve_id", {27'b0, irq_id}, 32'd3);
        ack_cycle();

        // Async reset during SERVICE with line 2 held high
        sig = 32'h4;
        cyc();
        HRESETn = 0;
        #2;
        check("arst_busy", {31'b0, irq_busy}, 32'd0);
        check("arst_req", {31'b0, irq_req}, 32'd0);
        psel = 1; pen = 1; pwr = 0; paddr = 12'(1 << 2);
        #1;
        check("arst_pend", PRDATA, 32'd0);
        psel = 0; pen = 0;
        @(posedge HCLK); #1;
        HRESETn = 1;
        model_reset();
        cyc();
        apb_read(1, rd); check("held_line_edge", rd, 32'h4);

        // Randomized traffic against the model
        apb_write(0, $urandom | 32'h0000_0F0F);
        apb_write(5, {31'b0, 1'($urandom)});
        for (int n = 0; n < 600; n++) begin
            sig = $urandom & $urandom & $urandom;
            irq_ack = ($urandom_range(0, 2) == 0);
            psel = 0; pen = 0; pwr = 0;
            if (m_busy && $urandom_range(0, 3) == 0) begin
                psel = 1; pen = 1; pwr = 1; paddr = 12'(4 << 2); pwdata = $urandom;
            end else if ($urandom_range(0, 3) == 0) begin
                psel = 1; pen = 1; pwr = 1'($urandom);
                paddr = 12'($urandom_range(0, 7) << 2);
                pwdata = $urandom & $urandom;
                if (n % 97 == 0) begin
                    paddr = 12'(5 << 2); pwdata = $urandom;
                end
            end
            cyc();
        end
        psel = 0; pen = 0; pwr = 0; irq_ack = 0; sig = 0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_irq_sequencer.md
Name: apb_irq_sequencer

Overview:
- APB-configurable interrupt sequencer for 32 event lines; delivers one interrupt at a time to the core over a req/ack handshake.
- Detects rising edges on event lines into a pending vector, masks them, and arbitrates (fixed or round-robin).
- Tracks the in-service interrupt until software writes EOI; sits between event sources and the core IRQ port.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width; only PADDR[4:2] decoded.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- PADDR  in  APB_ADDR_WIDTH  APB address
- PWDATA  in  32  APB write data
- PWRITE  in  1  APB write strobe
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PRDATA  out  32  APB read data
- PREADY  out  1  constant 1
- PSLVERR  out  1  constant 0
- signal_i  in  32  event lines, synchronous to HCLK
- irq_req_o  out  1  interrupt request to core (registered)
- irq_id_o  out  5  id of requested or in-service line (registered)
- irq_ack_i  in  1  core accepts the current request
- irq_busy_o  out  1  high while an interrupt is in service (registered)

Behaviour:
- Reset, HRESETn low, async: mask=0, pending=0, sig_q=0, rr_ptr=0, mode=0, FSM=IDLE, irq_req_o=0, irq_id_o=0, irq_busy_o=0.
- Because sig_q resets to 0, a line held high at reset release registers one edge on the first clock.
- APB write when PSEL&&PENABLE&&PWRITE; read when PSEL&&PENABLE&&!PWRITE. Zero wait states.
- PRDATA is combinational and is 0 when not reading.
- Register map (PADDR[4:2]):
  - 0 MASK, RW.
  - 1 PENDING: read returns pending; write is W1S.
  - 2 CLEAR: W1C on pending; reads 0.
  - 3 STATUS, RO: {22'b0, state[1:0], irq_busy_o, irq_req_o, 1'b0, irq_id_o}.
  - 4 EOI: any write; reads 0.
  - 5 MODE: bit0 selects 0=fixed, 1=round-robin; other bits read 0.
  - 6, 7: read 0, writes ignored.
- Edge detect:
  - edge = signal_i & ~sig_q; sig_q <= signal_i every cycle.
  - Each cycle, in this order: next pending = (pending & ~CLEAR_wdata & ~ack_clear) | PENDING_wdata | edge. Set always wins over clear on the same bit.
- Eligible vector = pending & mask.
- Fixed mode: lowest set index wins.
- RR mode: first set index searched upward from rr_ptr, wrapping 31->0.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if eligible != 0, latch winner into irq_id_o, set irq_req_o=1, go to REQ.
  - REQ: irq_id_o is held stable; no re-arbitration.
    - If irq_ack_i: clear pending[id] (ack_clear), irq_req_o=0, irq_busy_o=1, rr_ptr=id+1 mod 32, go to SERVICE.
    - Else if pending[id] or mask[id] reads 0 this cycle (CLEAR or MASK write): retract. irq_req_o=0, go to IDLE.
    - Ack and a same-cycle CLEAR/mask write: ack wins.
  - SERVICE: wait for an EOI write, then irq_busy_o=0 and go to IDLE. A new edge on the in-service line re-sets pending and is serviced again after EOI.
- EOI writes in IDLE or REQ are ignored.
- irq_ack_i outside REQ is ignored.
- Latency: signal_i low at posedge N-1 and high at posedge N gives pending=1 after posedge N and irq_req_o=1 after posedge N+1 (FSM idle, line masked-in).
- Back-to-back: after EOI at posedge M, the next eligible request asserts after posedge M+1.
- Reset asserted mid-operation returns everything to reset values immediately; pending events are lost.

Test Plan:
- Reset, MASK=0x1, pulse signal_i[0] -> pending=0x1 after edge N, irq_req_o=1 and irq_id_o=0 after N+1; ack -> irq_busy_o=1, pending=0; EOI -> irq_busy_o=0, STATUS state=IDLE.
- Fixed mode, MASK=0xFFFFFFFF, PENDING W1S 0x00008010 -> id 4 served first, then id 15 after EOI; RR mode with rr_ptr=5 and same pending -> id 15 first, then id 4 (wrap).
- RR wrap: service id 31 -> rr_ptr=0; pending 0x80000001 re-set -> id 0 chosen next.
- Retract: in REQ for id 7, write CLEAR=0x80 -> irq_req_o=0 next cycle, FSM IDLE; repeat with irq_ack_i in the same cycle -> ack wins, SERVICE with id 7.
- Collisions: edge on line 3 in the same cycle as CLEAR=0x8 -> pending[3]=1. Edge on the in-service line -> pending set and re-requested after EOI. Masked line edge -> pending set, no request until MASK enables it.
- Async reset during SERVICE -> irq_busy_o=0, irq_req_o=0, pending=0 immediately. signal_i[2] held high through reset -> pending[2]=1 after first clock.
